// File: rtl/common_pkg.sv
// Shared NoC types, default widths and the receive-bridge FSM encoding.
// The NoC packet is packed as {data, last, addr}, with data in the most significant bits.
package common_pkg;

    localparam int DEFAULT_D_W           = 32;
    localparam int DEFAULT_A_W           = 4;
    localparam int DEFAULT_VC_W          = 2;
    localparam int DEFAULT_VC_FIFO_DEPTH = 32;
    localparam int DEFAULT_TID_W         = 4;
    localparam int DEFAULT_TDEST_W       = 4;

    localparam int VC_IDX_W = $clog2(DEFAULT_VC_W);

    typedef struct packed {
        logic [DEFAULT_D_W-1:0] data;
        logic                   last;
        logic [DEFAULT_A_W-1:0] addr;
    } noc_packet_s;

    localparam int NOC_PACKET_W = $bits(noc_packet_s);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } noc_axis_rx_state_e;

endpackage

// File: rtl/noc_vc_fifo.sv
// Single virtual-channel FIFO.
// It holds DEPTH-1 beats, and the head beat is presented combinationally on rd_data.
module noc_vc_fifo #(
    parameter int W     = 37,
    parameter int DEPTH = 32,
    localparam int CNT_W = $clog2(DEPTH),
    localparam int SLOTS = DEPTH - 1,
    localparam int PTR_W = (SLOTS > 1) ? $clog2(SLOTS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [W-1:0]     wr_data,
    input  logic             rd_en,
    output logic [W-1:0]     rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [W-1:0]     mem [SLOTS];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_ok;
    logic             rd_ok;

    // Full is taken from the registered count.
    // A pop in the same cycle therefore does not open room for that cycle's write.
    assign full    = (count == CNT_W'(SLOTS));
    assign empty   = (count == '0);
    assign wr_ok   = wr_en && !full;
    assign rd_ok   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(SLOTS - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_ok) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/noc_axis_rx.sv
// NoC-to-AXI-Stream receive bridge: per-VC buffering, then round-robin packet-atomic streaming.
// Optional feature: define NOC_AXIS_RX_PKT_CNT_EN to add the o_pkt_cnt packet counter.
module noc_axis_rx
    import common_pkg::*;
#(
    parameter int D_W           = DEFAULT_D_W,
    parameter int A_W           = DEFAULT_A_W,
    parameter int VC_W          = DEFAULT_VC_W,
    parameter int VC_FIFO_DEPTH = DEFAULT_VC_FIFO_DEPTH,
    parameter int TID_W         = DEFAULT_TID_W,
    parameter int TDEST_W       = DEFAULT_TDEST_W,
    localparam int PKT_W        = D_W + 1 + A_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [VC_W-1:0]    i_noc_vc_valid,
    input  logic [PKT_W-1:0]   i_noc_packet,
    output logic [VC_W-1:0]    o_noc_credit,
    output logic               m_axis_tvalid,
    input  logic               m_axis_tready,
    output logic [D_W-1:0]     m_axis_tdata,
    output logic               m_axis_tlast,
    output logic [TID_W-1:0]   m_axis_tid,
    output logic [TDEST_W-1:0] m_axis_tdest,
    output logic               o_proto_err
`ifdef NOC_AXIS_RX_PKT_CNT_EN
    ,
    output logic [31:0]        o_pkt_cnt
`endif
);

    localparam int IDX_W = (VC_W > 1) ? $clog2(VC_W) : 1;
    localparam int CNT_W = $clog2(VC_FIFO_DEPTH);

    noc_axis_rx_state_e state_q, state_d;
    logic [IDX_W-1:0]   lock_q, lock_d;
    logic [IDX_W-1:0]   rr_q, rr_d;

    logic [VC_W-1:0]    wr_en;
    logic [VC_W-1:0]    rd_en;
    logic [VC_W-1:0]    full_v;
    logic [VC_W-1:0]    empty_v;
    logic [VC_W-1:0]    ovf_v;
    logic [PKT_W-1:0]   head_v [VC_W];
    logic [CNT_W-1:0]   cnt_v  [VC_W];

    logic               wr_onehot;
    logic               multi_hot;
    logic [PKT_W-1:0]   head;
    logic               head_last;
    logic               pop;
    logic               sel_found;
    logic [IDX_W-1:0]   sel_vc;

    assign wr_onehot = $onehot(i_noc_vc_valid);
    assign multi_hot = (i_noc_vc_valid != '0) && !wr_onehot;

    for (genvar v = 0; v < VC_W; v++) begin : g_vc
        assign wr_en[v] = wr_onehot && i_noc_vc_valid[v];
        assign rd_en[v] = pop && (lock_q == IDX_W'(v));
        assign ovf_v[v] = wr_en[v] && full_v[v];

        noc_vc_fifo #(
            .W     (PKT_W),
            .DEPTH (VC_FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .rst_n   (rst_n),
            .wr_en   (wr_en[v]),
            .wr_data (i_noc_packet),
            .rd_en   (rd_en[v]),
            .rd_data (head_v[v]),
            .count   (cnt_v[v]),
            .full    (full_v[v]),
            .empty   (empty_v[v])
        );
    end

    assign head      = head_v[lock_q];
    assign head_last = head[A_W];

    // Outputs read zero unless a beat is actually presented, including while reset is asserted.
    assign m_axis_tvalid = rst_n && (state_q == ST_STREAM) && (cnt_v[lock_q] != '0);
    assign m_axis_tdata  = m_axis_tvalid ? head[PKT_W-1 -: D_W] : '0;
    assign m_axis_tlast  = m_axis_tvalid && head_last;
    assign m_axis_tid    = m_axis_tvalid ? TID_W'(lock_q) : '0;
    assign m_axis_tdest  = m_axis_tvalid ? TDEST_W'(head[A_W-1:0]) : '0;
    assign pop           = m_axis_tvalid && m_axis_tready;

    always_comb begin
        int idx;
        idx       = 0;
        sel_found = 1'b0;
        sel_vc    = '0;
        state_d   = state_q;
        lock_d    = lock_q;
        rr_d      = rr_q;

        // rr_q holds the last-served VC; the search starts with the VC after it.
        for (int i = 1; i <= VC_W; i++) begin
            idx = (int'(rr_q) + i) % VC_W;
            if (!sel_found && !empty_v[IDX_W'(idx)]) begin
                sel_found = 1'b1;
                sel_vc    = IDX_W'(idx);
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (sel_found) begin
                    state_d = ST_STREAM;
                    lock_d  = sel_vc;
                    rr_d    = sel_vc;
                end
            end
            ST_STREAM: begin
                if (pop && head_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            lock_q       <= '0;
            rr_q         <= '0;
            o_noc_credit <= '0;
            o_proto_err  <= 1'b0;
        end else begin
            state_q      <= state_d;
            lock_q       <= lock_d;
            rr_q         <= rr_d;
            o_noc_credit <= rd_en;
            if (multi_hot || (ovf_v != '0)) begin
                o_proto_err <= 1'b1;
            end
        end
    end

`ifdef NOC_AXIS_RX_PKT_CNT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            o_pkt_cnt <= '0;
        end else if (pop && head_last) begin
            o_pkt_cnt <= o_pkt_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_noc_axis_rx.sv
// Directed bench for noc_axis_rx.
// Per-VC expected queues are filled as beats are driven and drained by a negedge monitor.
module tb_noc_axis_rx;
  import common_pkg::*;

  localparam int D_W     = DEFAULT_D_W;
  localparam int A_W     = DEFAULT_A_W;
  localparam int VC_W    = DEFAULT_VC_W;
  localparam int TID_W   = DEFAULT_TID_W;
  localparam int TDEST_W = DEFAULT_TDEST_W;
  localparam int EXP_W   = D_W + 1 + TID_W + TDEST_W;

  logic                    clk;
  logic                    rst_n;
  logic [VC_W-1:0]         i_noc_vc_valid;
  logic [NOC_PACKET_W-1:0] i_noc_packet;
  logic [VC_W-1:0]         o_noc_credit;
  logic                    m_axis_tvalid;
  logic                    m_axis_tready;
  logic [D_W-1:0]          m_axis_tdata;
  logic                    m_axis_tlast;
  logic [TID_W-1:0]        m_axis_tid;
  logic [TDEST_W-1:0]      m_axis_tdest;
  logic                    o_proto_err;
`ifdef NOC_AXIS_RX_PKT_CNT_EN
  logic [31:0]             o_pkt_cnt;
`endif

  int checks = 0;
  int errors = 0;
  logic [EXP_W-1:0] exp_q0[$];
  logic [EXP_W-1:0] exp_q1[$];
  int done_tid_q[$];
  int credit_cnt0 = 0;
  int credit_cnt1 = 0;

  noc_axis_rx dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_noc_vc_valid (i_noc_vc_valid),
    .i_noc_packet   (i_noc_packet),
    .o_noc_credit   (o_noc_credit),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tlast   (m_axis_tlast),
    .m_axis_tid     (m_axis_tid),
    .m_axis_tdest   (m_axis_tdest),
    .o_proto_err    (o_proto_err)
`ifdef NOC_AXIS_RX_PKT_CNT_EN
    ,
    .o_pkt_cnt      (o_pkt_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input int vc, input logic [D_W-1:0] data, input logic last,
                            input logic [A_W-1:0] addr, input bit accept);
    logic [EXP_W-1:0] e;
    i_noc_vc_valid = VC_W'(1) << vc;
    i_noc_packet   = {data, last, addr};
    e = {data, last, TID_W'(vc), TDEST_W'(addr)};
    if (accept) begin
      if (vc == 0) exp_q0.push_back(e);
      else         exp_q1.push_back(e);
    end
    tick();
    i_noc_vc_valid = '0;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    i_noc_vc_valid = '0;
    exp_q0.delete();
    exp_q1.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_drain(input int max_cycles, input bit toggle);
    int n;
    n = 0;
    while ((exp_q0.size() + exp_q1.size()) != 0 && n < max_cycles) begin
      if (toggle) m_axis_tready = ~m_axis_tready;
      tick();
      n++;
    end
    check("drain_left", 64'(exp_q0.size() + exp_q1.size()), 64'd0);
  endtask

  // scoreboard / monitor
  logic [VC_W-1:0]  exp_credit = '0;
  logic             hold_v = 1'b0;
  logic [EXP_W-1:0] hold_beat = '0;
  int               cur_vc = -1;

  always @(negedge clk) begin
    logic [EXP_W-1:0] obs;
    logic [EXP_W-1:0] exp_b;
    obs = {m_axis_tdata, m_axis_tlast, m_axis_tid, m_axis_tdest};
    if (o_noc_credit[0]) credit_cnt0++;
    if (o_noc_credit[1]) credit_cnt1++;
    check("credit_pulse", 64'(o_noc_credit), 64'(exp_credit));
    if (hold_v && rst_n) check("stall_hold", 64'({m_axis_tvalid, obs}), 64'({1'b1, hold_beat}));
    exp_credit = '0;
    hold_v     = 1'b0;
    if (rst_n && m_axis_tvalid) begin
      if (cur_vc >= 0) check("no_interleave", 64'(m_axis_tid), 64'(cur_vc));
      if (m_axis_tready) begin
        exp_credit = VC_W'(1) << m_axis_tid;
        if (m_axis_tid == 0 && exp_q0.size() != 0) begin
          exp_b = exp_q0.pop_front();
          check("beat_vc0", 64'(obs), 64'(exp_b));
        end else if (m_axis_tid == 1 && exp_q1.size() != 0) begin
          exp_b = exp_q1.pop_front();
          check("beat_vc1", 64'(obs), 64'(exp_b));
        end else begin
          check("unexpected_beat", 64'(obs), 64'd0);
        end
        if (m_axis_tlast) begin
          done_tid_q.push_back(int'(m_axis_tid));
          cur_vc = -1;
        end else begin
          cur_vc = int'(m_axis_tid);
        end
      end else begin
        hold_v    = 1'b1;
        hold_beat = obs;
      end
    end
    if (!rst_n) begin
      cur_vc     = -1;
      exp_credit = '0;
    end
  end

  // directed sequence
  initial begin
    rst_n          = 1'b0;
    i_noc_vc_valid = '0;
    i_noc_packet   = '0;
    m_axis_tready  = 1'b0;
    tick();
    tick();
    check("rst_tdata", 64'(m_axis_tdata), 64'd0);
    check("rst_tid", 64'(m_axis_tid), 64'd0);
    check("rst_tdest", 64'(m_axis_tdest), 64'd0);
    rst_n = 1'b1;
    tick();
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_credit", 64'(o_noc_credit), 64'd0);
    check("rst_err", 64'(o_proto_err), 64'd0);

    // single 3-beat packet on VC1, latency 2
    m_axis_tready = 1'b1;
    drive_beat(1, 32'h1111_0001, 1'b0, 4'h3, 1'b1);
    check("lat_c1_tvalid", 64'(m_axis_tvalid), 64'd0);
    drive_beat(1, 32'h1111_0002, 1'b0, 4'h3, 1'b1);
    check("lat_c2_tvalid", 64'(m_axis_tvalid), 64'd1);
    check("lat_c2_tid", 64'(m_axis_tid), 64'd1);
    drive_beat(1, 32'h1111_0003, 1'b1, 4'h3, 1'b1);
    wait_drain(20, 1'b0);
    repeat (3) tick();
    check("p1_credits_vc1", 64'(credit_cnt1), 64'd3);
    check("p1_credits_vc0", 64'(credit_cnt0), 64'd0);
    check("p1_pkts", 64'(done_tid_q.size()), 64'd1);
    done_tid_q.delete();

    // interleaved writes on VC0/VC1, packet-atomic output
    credit_cnt0 = 0;
    credit_cnt1 = 0;
    for (int i = 0; i < 3; i++) begin
      drive_beat(0, 32'hA000_0000 + i, (i == 2), 4'h5, 1'b1);
      drive_beat(1, 32'hB000_0000 + i, (i == 2), 4'h6, 1'b1);
    end
    wait_drain(40, 1'b0);
    repeat (3) tick();
    check("il_pkts", 64'(done_tid_q.size()), 64'd2);
    if (done_tid_q.size() == 2) begin
      check("il_first_vc", 64'(done_tid_q[0]), 64'd0);
      check("il_second_vc", 64'(done_tid_q[1]), 64'd1);
    end
    check("il_credits_vc0", 64'(credit_cnt0), 64'd3);
    check("il_credits_vc1", 64'(credit_cnt1), 64'd3);
    done_tid_q.delete();

    // multi-hot valid
    i_noc_vc_valid = 2'b11;
    i_noc_packet   = {32'hDEAD_BEEF, 1'b1, 4'h1};
    tick();
    i_noc_vc_valid = '0;
    tick();
    check("mh_err", 64'(o_proto_err), 64'd1);
    repeat (3) tick();
    check("mh_no_output", 64'(m_axis_tvalid), 64'd0);
    do_reset();
    check("mh_err_cleared", 64'(o_proto_err), 64'd0);

    // fill VC0, overflow while stalled, then overflow on full+pop cycle
    credit_cnt0 = 0;
    m_axis_tready = 1'b0;
    for (int i = 0; i < 31; i++) begin
      drive_beat(0, 32'hC000_0000 + i, (i == 30), 4'h7, 1'b1);
    end
    check("full_no_err", 64'(o_proto_err), 64'd0);
    drive_beat(0, 32'hDEAD_0032, 1'b0, 4'h7, 1'b0);
    check("full_drop_err", 64'(o_proto_err), 64'd1);
    m_axis_tready = 1'b1;
    drive_beat(0, 32'hBEEF_0033, 1'b1, 4'h7, 1'b0);
    wait_drain(80, 1'b0);
    repeat (5) tick();
    check("full_credits_vc0", 64'(credit_cnt0), 64'd31);
    check("full_idle_after", 64'(m_axis_tvalid), 64'd0);
    done_tid_q.delete();
    do_reset();

    // tready toggling during a 4-beat packet
    credit_cnt1 = 0;
    m_axis_tready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_axis_tready = ~m_axis_tready;
      drive_beat(1, 32'hD000_0000 + i, (i == 3), 4'h9, 1'b1);
    end
    wait_drain(40, 1'b1);
    m_axis_tready = 1'b1;
    repeat (3) tick();
    check("tog_credits_vc1", 64'(credit_cnt1), 64'd4);
    done_tid_q.delete();

    // packet count, then reset mid-packet
    do_reset();
    m_axis_tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_beat(i % 2, 32'hE000_0000 + i, 1'b1, 4'h2, 1'b1);
    end
    wait_drain(40, 1'b0);
    repeat (3) tick();
`ifdef NOC_AXIS_RX_PKT_CNT_EN
    check("pkt_cnt_5", 64'(o_pkt_cnt), 64'd5);
`endif
    check("cnt_pkts", 64'(done_tid_q.size()), 64'd5);
    done_tid_q.delete();
    m_axis_tready = 1'b0;
    drive_beat(0, 32'hF000_0000, 1'b0, 4'hA, 1'b1);
    drive_beat(0, 32'hF000_0001, 1'b0, 4'hA, 1'b1);
    check("mid_tvalid", 64'(m_axis_tvalid), 64'd1);
    rst_n = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    tick();
    check("mid_rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("mid_rst_tdata", 64'(m_axis_tdata), 64'd0);
    check("mid_rst_credit", 64'(o_noc_credit), 64'd0);
`ifdef NOC_AXIS_RX_PKT_CNT_EN
    check("mid_rst_pkt_cnt", 64'(o_pkt_cnt), 64'd0);
`endif
    tick();
    rst_n = 1'b1;
    m_axis_tready = 1'b1;
    repeat (4) tick();
    check("mid_after_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("mid_after_err", 64'(o_proto_err), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/noc_axis_rx.md
NOC_AXIS_RX -- requirements
Module: noc_axis_rx

Interface
REQ-001 SHALL have parameter D_W, default common_pkg::DEFAULT_D_W, payload data width.
REQ-002 SHALL have parameter A_W, default common_pkg::DEFAULT_A_W, route address width.
REQ-003 SHALL have parameter VC_W, default common_pkg::DEFAULT_VC_W, number of virtual channels (one bit per VC).
REQ-004 SHALL have parameter VC_FIFO_DEPTH, default common_pkg::DEFAULT_VC_FIFO_DEPTH; each VC buffer holds VC_FIFO_DEPTH-1 beats.
REQ-005 SHALL have parameters TID_W and TDEST_W, defaults DEFAULT_TID_W and DEFAULT_TDEST_W.
REQ-006 SHALL have ports, with one clock and a synchronous, active-low reset:
- clk  in  1  sole clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- i_noc_vc_valid  in  VC_W  one-hot beat-valid per VC
- i_noc_packet  in  NOC_PACKET_W  {data, last, addr} beat
- o_noc_credit  out  VC_W  one-cycle credit-return pulse per VC
- m_axis_tvalid  out  1  AXIS beat valid
- m_axis_tready  in  1  AXIS sink ready
- m_axis_tdata  out  D_W  beat data
- m_axis_tlast  out  1  end of packet
- m_axis_tid  out  TID_W  source VC index, zero-extended
- m_axis_tdest  out  TDEST_W  addr, zero-extended
- o_proto_err  out  1  sticky protocol-error flag

Function
REQ-007 SHALL write i_noc_packet into the FIFO of VC v when i_noc_vc_valid equals exactly bit v.
REQ-008 SHALL, on a multi-hot i_noc_vc_valid, write nothing and set o_proto_err.
REQ-009 SHALL, on a write to a full VC FIFO (VC_FIFO_DEPTH-1 entries), drop the beat, keep the FIFO unchanged and set o_proto_err.
REQ-010 SHALL have a two-state FSM, IDLE and STREAM; in IDLE it selects the next non-empty VC round-robin, starting after the last-served VC.
REQ-011 SHALL move IDLE->STREAM on selection; in STREAM it serves only the locked VC until a beat with tlast=1 is accepted, then returns to IDLE.
REQ-012 SHALL drive m_axis_tvalid only in STREAM with the locked FIFO non-empty; it SHALL hold tdata/tlast/tid/tdest stable while tvalid=1 and tready=0.
REQ-013 SHALL pop on tvalid&&tready and pulse o_noc_credit[v] high for exactly the next cycle.
REQ-014 SHALL give minimum latency 2 cycles from write to tvalid for an idle block (1 cycle write, 1 cycle IDLE->STREAM).
REQ-015 SHALL, on a simultaneous write and pop on the same VC, keep its occupancy unchanged; a full FIFO popped in a cycle still rejects that cycle's write.
REQ-016 SHALL wrap FIFO pointers modulo VC_FIFO_DEPTH-1, with occupancy counters of width $clog2(VC_FIFO_DEPTH).
REQ-017 SHALL, in STREAM with the locked FIFO empty mid-packet, hold tvalid=0 and stay locked.

Reset
REQ-018 SHALL, with rst_n=0 at a clock edge, empty all FIFOs, enter IDLE, set the round-robin pointer to VC 0, and clear o_noc_credit, m_axis_tvalid and o_proto_err.
REQ-019 SHALL hold tdata/tid/tdest at 0 during reset; a packet in flight at reset is discarded with no credits returned.

Configuration
REQ-020 SHALL, with NOC_AXIS_RX_PKT_CNT_EN defined, add output o_pkt_cnt (32 bits), reset to 0 and incremented per accepted tlast beat, wrapping at 2^32.
REQ-021 SHALL, without NOC_AXIS_RX_PKT_CNT_EN, have neither the port nor its counter logic.

Structure
REQ-022 SHALL take from common_pkg the noc_packet_s type, NOC_PACKET_W and the defaults; the FSM enum noc_axis_rx_state_e and VC_IDX_W=$clog2(DEFAULT_VC_W) SHALL be added to common_pkg.
REQ-023 SHALL use one sub-module, noc_vc_fifo (single-VC FIFO with count/full/empty), instantiated VC_W times.

Verification
REQ-024 Single 3-beat packet on VC1, tready=1: tvalid at cycle 2, tid=1, tlast on 3rd beat, three o_noc_credit[1] pulses.
REQ-025 Packets on VC0 and VC1 written interleaved: output is VC0 packet fully then VC1 packet, beats never interleaved.
REQ-026 Fill VC0 with 31 beats, tready=0, write 32nd: beat dropped, o_proto_err=1, 31 beats later drained intact.
REQ-027 i_noc_vc_valid=2'b11: nothing written, o_proto_err=1; rst_n=0 clears it.
REQ-028 tready toggled 0/1 each cycle during a 4-beat packet: outputs stable while stalled, 4 credits, data in order.
REQ-029 With NOC_AXIS_RX_PKT_CNT_EN, 5 packets accepted -> o_pkt_cnt=5; reset mid-packet -> o_pkt_cnt=0, tvalid=0 next cycle.
